// File: rtl/uart_number_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_number_tx_if
// Description : Request/number/status bundle for the hex-number UART sender.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_number_tx_if #(
  parameter int NUMBER_WIDTH = 16
);
  logic                    send;
  logic [NUMBER_WIDTH-1:0] number;
  logic                    busy;
  logic                    done;
  logic                    usb_tx;

  modport master (
    output send,
    output number,
    input  busy,
    input  done,
    input  usb_tx
  );

  modport slave (
    input  send,
    input  number,
    output busy,
    output done,
    output usb_tx
  );
endinterface
`default_nettype wire

// File: rtl/uart_number_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_number_tx
// Description : Sends a latched number as uppercase ASCII hex + CR LF, 8N1.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_number_tx #(
  parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int BAUD_RATE                   = 115_200,
  parameter int NUMBER_OF_DIGITS            = 4,
  parameter int NUMBER_OF_BITS_PER_DIGIT    = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  uart_number_tx_if.slave  bus
);

  localparam int c_clks_per_bit = BOARD_CLOCK_FREQUENCY_IN_HZ / BAUD_RATE;
  localparam int c_baud_w       = $clog2(c_clks_per_bit);
  localparam int c_num_w        = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
  localparam int c_char_w       = $clog2(NUMBER_OF_DIGITS + 2);
  localparam int c_last_char    = NUMBER_OF_DIGITS + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state,  w_state_next;
  logic [c_baud_w-1:0] r_baud,   w_baud_next;
  logic [2:0]          r_bit,    w_bit_next;
  logic [c_char_w-1:0] r_char,   w_char_next;
  logic [c_num_w-1:0]  r_shadow, w_shadow_next;
  logic                r_tx,     w_tx_next;
  logic                r_busy,   w_busy_next;
  logic                r_done,   w_done_next;
  logic                w_wrap;
  logic [7:0]          w_char;

  // Character idx of the frame: digits MSB-first, then CR, then LF.
  function automatic logic [7:0] f_char(input logic [c_char_w-1:0] idx,
                                        input logic [c_num_w-1:0]  sh);
    logic [3:0] v;
    logic [7:0] ch;
    v = 4'h0;
    for (int d = 0; d < NUMBER_OF_DIGITS; d++) begin
      if (idx == c_char_w'(NUMBER_OF_DIGITS - 1 - d)) begin
        for (int b = 0; b < 4 && b < NUMBER_OF_BITS_PER_DIGIT; b++) begin
          v[b] = sh[d*NUMBER_OF_BITS_PER_DIGIT + b];
        end
      end
    end
    if (idx == c_char_w'(NUMBER_OF_DIGITS)) begin
      ch = 8'h0D;
    end else if (idx == c_char_w'(NUMBER_OF_DIGITS + 1)) begin
      ch = 8'h0A;
    end else if (v < 4'd10) begin
      ch = 8'h30 + {4'h0, v};
    end else begin
      ch = 8'h37 + {4'h0, v};
    end
    return ch;
  endfunction

  assign w_char = f_char(r_char, r_shadow);
  assign w_wrap = (r_baud == c_baud_w'(c_clks_per_bit - 1));

  always_comb begin
    w_state_next  = r_state;
    w_baud_next   = r_baud;
    w_bit_next    = r_bit;
    w_char_next   = r_char;
    w_shadow_next = r_shadow;
    w_tx_next     = r_tx;
    w_busy_next   = r_busy;
    w_done_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_next   = 1'b1;
        w_busy_next = 1'b0;
        if (bus.send) begin
          w_state_next  = S_START;
          w_shadow_next = bus.number;
          w_char_next   = '0;
          w_baud_next   = '0;
          w_bit_next    = 3'd0;
          w_tx_next     = 1'b0;
          w_busy_next   = 1'b1;
        end
      end
      S_START: begin
        if (w_wrap) begin
          w_baud_next  = '0;
          w_bit_next   = 3'd0;
          w_state_next = S_DATA;
          w_tx_next    = w_char[0];
        end else begin
          w_baud_next = r_baud + c_baud_w'(1);
        end
      end
      S_DATA: begin
        if (w_wrap) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_next = r_bit + 3'd1;
            w_tx_next  = w_char[r_bit + 3'd1];
          end
        end else begin
          w_baud_next = r_baud + c_baud_w'(1);
        end
      end
      S_STOP: begin
        if (w_wrap) begin
          w_baud_next = '0;
          if (r_char < c_char_w'(c_last_char)) begin
            w_char_next  = r_char + c_char_w'(1);
            w_state_next = S_START;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
          end
        end else begin
          w_baud_next = r_baud + c_baud_w'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= 3'd0;
      r_char   <= '0;
      r_shadow <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_baud   <= w_baud_next;
      r_bit    <= w_bit_next;
      r_char   <= w_char_next;
      r_shadow <= w_shadow_next;
      r_tx     <= w_tx_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
    end
  end

  assign bus.usb_tx = r_tx;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: doc/uart_number_tx.md
Name: uart_number_tx

Overview:
- Transmit-side UART that replaces the usb_rx→usb_tx loopback in the top level.
- On request, captures the current display number and sends it over usb_tx as uppercase ASCII hex, MSB digit first, followed by CR LF.
- Format is 8N1, idle-high.
- Driven by the same debounced controls and number bus as the counter and display blocks.

Parameters:
- BOARD_CLOCK_FREQUENCY_IN_HZ, 100_000_000, input clock frequency.
- BAUD_RATE, 115_200, serial bit rate. CLKS_PER_BIT = BOARD_CLOCK_FREQUENCY_IN_HZ / BAUD_RATE (integer truncation, must be ≥2).
- NUMBER_OF_DIGITS, 4, hex digits per frame.
- NUMBER_OF_BITS_PER_DIGIT, 4, width of each digit field in number.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- send, input, 1, transmit request; level-sampled in IDLE.
- number, input, NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT, value to send; digit 0 is the LSBs.
- busy, output, 1, high while a frame is in progress.
- done, output, 1, one-cycle pulse when a frame completes.
- usb_tx, output, 1, serial line; idle high.

Behaviour:
- Reset, asynchronous, any state:
  - usb_tx=1, busy=0, done=0.
  - FSM goes to IDLE; bit, byte and baud counters clear.
  - Takes effect in the same cycle, including mid-bit. No partial-frame completion and no done pulse.
- FSM states:
  - IDLE → START on send=1 at a clock edge. At that edge, number is latched into an internal shadow register and char index=0.
  - START: usb_tx=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each → STOP.
  - STOP: usb_tx=1 for CLKS_PER_BIT cycles. If char index < NUMBER_OF_DIGITS+1, increment it and go to START; otherwise go to IDLE.
- Character sequence, indices 0..NUMBER_OF_DIGITS+1:
  - Shadow digits from the most significant digit down to digit 0, then 0x0D, then 0x0A.
  - Each digit's low 4 bits are used (zero-extended if NUMBER_OF_BITS_PER_DIGIT<4).
  - Digit value 0–9 encodes to 0x30+v; value 10–15 encodes to 0x41+(v-10).
- Latency:
  - Start bit of the first char drives usb_tx on the cycle after send is accepted.
  - Frame length = (NUMBER_OF_DIGITS+2)*10*CLKS_PER_BIT cycles.
- busy: 1 from the cycle after acceptance through the last stop-bit cycle, inclusive. It is 0 in IDLE.
- done: 1 for exactly the first IDLE cycle after a completed frame.
  - send sampled in that same cycle is accepted.
  - Back-to-back frames therefore have exactly one idle-high cycle between the final stop bit and the next start bit.
- Simultaneous and mid-frame events:
  - send while busy=1 is ignored, not queued.
  - number changes after acceptance do not affect the frame in flight.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. The bit transition occurs on the wrap edge. No fractional-baud correction.
- usb_tx is registered; it carries no combinational path from inputs.

Test Plan (bench overrides BOARD_CLOCK_FREQUENCY_IN_HZ=1000, BAUD_RATE=100, so CLKS_PER_BIT=10):
- Reset: assert rst asynchronously → usb_tx=1, busy=0, done=0 before the next clk edge; outputs hold for 20 cycles with send=0.
- Basic frame: number=0x1A3F, 1-cycle send accepted at edge k → start bit at k+1. Decoded bytes are 0x31, 0x41, 0x33, 0x46, 0x0D, 0x0A, each bit 10 cycles. busy=1 for 600 cycles; done=1 only at cycle k+601.
- Ignore while busy: during the frame, pulse send and change number to 0x0000 → frame bytes unchanged, exactly one done, no second frame.
- Back-to-back: hold send=1 continuously → consecutive frames. Exactly one usb_tx=1 idle cycle (the done cycle) between the final LF stop bit and the next start bit.
- Reset mid-frame: assert rst during DATA bit 3 of the second char → usb_tx=1 immediately, busy=0, no done pulse. A subsequent send with number=0x0000 yields "0000\r\n" complete and correct.
- Encoding boundaries: number=0x9999 → "9999\r\n"; number=0xFFFF → "FFFF\r\n"; number=0xA0F9 → bytes 0x41, 0x30, 0x46, 0x39, 0x0D, 0x0A.
